sib_keccak_byte_feeder: RTL

Upstream feeder for the SampleInBall sampler in the ML-DSA challenge path. Takes 64-bit SHAKE256 squeeze words from the Keccak core and captures the first word as the 64-bit sign buffer. Every later word is serialized into a one-byte-per-cycle candidate stream (valid/ready) for the sampler. It tracks rate-block boundaries, requests further permutations, and flushes all held state when the sampler reports completion.

---
 rtl/sib_keccak_byte_feeder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sib_keccak_byte_feeder.sv
// sib_keccak_byte_feeder
// Feeds the SampleInBall sampler from the SHAKE256 squeeze port. The first squeeze
// word of a challenge becomes the 64-bit sign buffer. Every later word is serialized
// little-endian into a one-byte-per-cycle candidate stream.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   zeroize           synchronous clear, highest priority, same effect as rst
//   start_i           begin a new challenge (honoured only in IDLE)
//   keccak_data_i     squeeze word
//   keccak_valid_i    squeeze word valid
//   keccak_ready_o    squeeze word accepted when valid && ready
//   squeeze_req_o     one-cycle pulse asking for the next permutation
//   sign_o            captured sign word
//   sign_valid_o      sign_o holds the captured word
//   byte_o            candidate byte
//   byte_valid_o      candidate byte valid
//   byte_ready_i      candidate byte consumed when valid && ready
//   sampler_done_i    sampler has placed all coefficients
//   done_o            one-cycle pulse ending the challenge
//   busy_o            high outside IDLE
module sib_keccak_byte_feeder #(
   parameter int unsigned WORD_W     = 64,
   parameter int unsigned RATE_WORDS = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              zeroize,
   input  logic              start_i,
   input  logic [WORD_W-1:0] keccak_data_i,
   input  logic              keccak_valid_i,
   output logic              keccak_ready_o,
   output logic              squeeze_req_o,
   output logic [WORD_W-1:0] sign_o,
   output logic              sign_valid_o,
   output logic [7:0]        byte_o,
   output logic              byte_valid_o,
   input  logic              byte_ready_i,
   input  logic              sampler_done_i,
   output logic              done_o,
   output logic              busy_o
);

   localparam int unsigned WcntW = $clog2(RATE_WORDS);

   typedef enum logic [1:0] {StIdle, StSign, StActive, StDone} state_e;

   state_e            r_state;
   logic [WORD_W-1:0] r_buf;
   logic [3:0]        r_byte_cnt;
   logic [WORD_W-1:0] r_sign;
   logic              r_sign_valid;
   logic [WcntW-1:0]  r_wcnt;
   logic              r_squeeze_req;

   logic w_byte_valid;
   logic w_byte_fire;
   logic w_keccak_ready;
   logic w_word_fire;
   logic w_wrap;

   assign w_byte_valid = (r_byte_cnt != 4'd0);
   assign w_byte_fire  = w_byte_valid && byte_ready_i;
   assign w_wrap       = (r_wcnt == WcntW'(RATE_WORDS - 1));

   // Refill when empty, or when the last held byte leaves this very cycle, so a
   // sustained stream has no bubble between words.
   always_comb begin
      w_keccak_ready = 1'b0;
      unique case (r_state)
         StSign:   w_keccak_ready = 1'b1;
         StActive: w_keccak_ready = (r_byte_cnt == 4'd0) ||
                                    ((r_byte_cnt == 4'd1) && byte_ready_i);
         default:  w_keccak_ready = 1'b0;
      endcase
   end

   // ready is not gated by sampler_done_i (keeps the only comb path byte_ready_i ->
   // keccak_ready_o); instead a coincident done blocks the acceptance internally.
   assign w_word_fire = keccak_valid_i && w_keccak_ready &&
                        !((r_state == StActive) && sampler_done_i);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= StIdle;
         r_buf         <= '0;
         r_byte_cnt    <= '0;
         r_sign        <= '0;
         r_sign_valid  <= 1'b0;
         r_wcnt        <= '0;
         r_squeeze_req <= 1'b0;
      end else if (zeroize) begin
         r_state       <= StIdle;
         r_buf         <= '0;
         r_byte_cnt    <= '0;
         r_sign        <= '0;
         r_sign_valid  <= 1'b0;
         r_wcnt        <= '0;
         r_squeeze_req <= 1'b0;
      end else begin
         r_squeeze_req <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (start_i) begin
                  r_state <= StSign;
                  r_wcnt  <= '0;
               end
            end
            StSign: begin
               if (w_word_fire) begin
                  r_sign       <= keccak_data_i;
                  r_sign_valid <= 1'b1;
                  r_state      <= StActive;
               end
            end
            StActive: begin
               if (sampler_done_i) begin
                  // Scrub every secret-derived register on the way out.
                  r_state      <= StDone;
                  r_buf        <= '0;
                  r_byte_cnt   <= '0;
                  r_sign       <= '0;
                  r_sign_valid <= 1'b0;
                  r_wcnt       <= '0;
               end else if (w_word_fire) begin
                  r_buf      <= keccak_data_i;
                  r_byte_cnt <= 4'd8;
               end else if (w_byte_fire) begin
                  r_buf      <= {8'h00, r_buf[WORD_W-1:8]};
                  r_byte_cnt <= r_byte_cnt - 4'd1;
               end
            end
            StDone: begin
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase

         // Word fires only in SIGN/ACTIVE, never alongside the clears above.
         if (w_word_fire) begin
            if (w_wrap) begin
               r_wcnt        <= '0;
               r_squeeze_req <= 1'b1;
            end else begin
               r_wcnt <= r_wcnt + WcntW'(1);
            end
         end
      end
   end

   assign keccak_ready_o = w_keccak_ready;
   assign squeeze_req_o  = r_squeeze_req;
   assign sign_o         = r_sign;
   assign sign_valid_o   = r_sign_valid;
   assign byte_o         = r_buf[7:0];
   assign byte_valid_o   = w_byte_valid;
   assign done_o         = (r_state == StDone);
   assign busy_o         = (r_state != StIdle);

endmodule
